qspi_psram_responder: RTL and testbench

QSPI_PSRAM_RESPONDER -- requirements
Module: qspi_psram_responder

---
 rtl/qspi_psram_responder.sv | 200 ++++++++++++++++++++
 tb/tb_qspi_psram_responder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_psram_responder.sv
// QSPI PSRAM-style responder: 1-bit command, quad address/data, a byte-wide
// internal memory with a backdoor write port for preload.
module qspi_psram_responder #(
  parameter int MEM_BYTES    = 256,
  parameter int DUMMY_CYCLES = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cs_n,
  input  logic        sclk,
  input  logic [3:0]  io_in,
  output logic [3:0]  io_out,
  output logic [3:0]  io_oe,
  input  logic        bd_we,
  input  logic [11:0] bd_addr,
  input  logic [7:0]  bd_wdata,
  output logic        bad_cmd,
  output logic [2:0]  dbg_state
);

  localparam int AW = $clog2(MEM_BYTES);
  localparam logic [7:0] CMD_READ  = 8'hEB;
  localparam logic [7:0] CMD_WRITE = 8'h38;
  localparam logic [7:0] DUMMY_LAST = (DUMMY_CYCLES > 0) ? 8'(DUMMY_CYCLES - 1) : 8'd0;

  // Bus handshake: there is none beyond SCLK edges; every rise/fall seen while
  // cs_n is low is consumed in the clk where it is detected.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    ADDR   = 3'd2,
    DUMMY  = 3'd3,
    RDATA  = 3'd4,
    WDATA  = 3'd5,
    IGNORE = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic        sclk_d_q;
  logic [7:0]  cmd_q, cmd_d;
  logic [23:0] addr_q, addr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        nib_sel_q, nib_sel_d;
  logic [3:0]  wr_hi_q, wr_hi_d;
  logic [3:0]  io_out_q, io_out_d;
  logic [3:0]  io_oe_q, io_oe_d;
  logic        bad_cmd_q, bad_cmd_d;

  logic [7:0]  mem_q [MEM_BYTES];
  logic        bus_we;
  logic [7:0]  bus_wdata;
  logic [7:0]  rd_byte;
  logic [7:0]  cmd_shift;
  logic        rise, fall;
  logic        unused_bits;

  assign rise      = sclk & ~sclk_d_q;
  assign fall      = ~sclk & sclk_d_q;
  assign cmd_shift = {cmd_q[6:0], io_in[0]};
  // Reads see the array as it was before this clk's writes.
  assign rd_byte   = mem_q[addr_q[AW-1:0]];

  assign io_out    = io_out_q;
  assign io_oe     = io_oe_q;
  assign bad_cmd   = bad_cmd_q;
  assign dbg_state = state_q;

  assign unused_bits = ^{bd_addr, addr_q};

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    nib_sel_d = nib_sel_q;
    wr_hi_d   = wr_hi_q;
    io_out_d  = io_out_q;
    io_oe_d   = io_oe_q;
    bad_cmd_d = 1'b0;
    bus_we    = 1'b0;
    bus_wdata = {wr_hi_q, io_in};

    if (cs_n) begin
      state_d   = IDLE;
      io_oe_d   = 4'h0;
      cnt_d     = 8'd0;
      nib_sel_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d   = CMD;
          nib_sel_d = 1'b0;
          cmd_d     = 8'h00;
          cnt_d     = 8'd0;
          if (rise) begin
            cmd_d = {7'b0, io_in[0]};
            cnt_d = 8'd1;
          end
        end
        CMD: begin
          if (rise) begin
            cmd_d = cmd_shift;
            if (cnt_q == 8'd7) begin
              cnt_d = 8'd0;
              if (cmd_shift == CMD_READ || cmd_shift == CMD_WRITE) begin
                state_d = ADDR;
              end else begin
                state_d   = IGNORE;
                bad_cmd_d = 1'b1;
              end
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end
        ADDR: begin
          if (rise) begin
            addr_d = {addr_q[19:0], io_in};
            if (cnt_q == 8'd5) begin
              cnt_d = 8'd0;
              if (cmd_q == CMD_READ) begin
                state_d = (DUMMY_CYCLES == 0) ? RDATA : DUMMY;
              end else begin
                state_d = WDATA;
              end
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end
        DUMMY: begin
          if (rise) begin
            if (cnt_q == DUMMY_LAST) begin
              cnt_d   = 8'd0;
              state_d = RDATA;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end
        RDATA: begin
          if (fall) begin
            io_oe_d   = 4'hF;
            io_out_d  = nib_sel_q ? rd_byte[3:0] : rd_byte[7:4];
            nib_sel_d = ~nib_sel_q;
            if (nib_sel_q) addr_d = addr_q + 24'd1;
          end
        end
        WDATA: begin
          if (rise) begin
            if (!nib_sel_q) begin
              wr_hi_d   = io_in;
              nib_sel_d = 1'b1;
            end else begin
              bus_we    = 1'b1;
              nib_sel_d = 1'b0;
              addr_d    = addr_q + 24'd1;
            end
          end
        end
        default: begin
          io_oe_d = 4'h0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sclk_d_q  <= 1'b0;
      cmd_q     <= 8'h00;
      addr_q    <= 24'h0;
      cnt_q     <= 8'd0;
      nib_sel_q <= 1'b0;
      wr_hi_q   <= 4'h0;
      io_out_q  <= 4'h0;
      io_oe_q   <= 4'h0;
      bad_cmd_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sclk_d_q  <= sclk;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      nib_sel_q <= nib_sel_d;
      wr_hi_q   <= wr_hi_d;
      io_out_q  <= io_out_d;
      io_oe_q   <= io_oe_d;
      bad_cmd_q <= bad_cmd_d;
    end
  end

  // Backdoor write is last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (bus_we) mem_q[addr_q[AW-1:0]] <= bus_wdata;
    if (bd_we)  mem_q[bd_addr[AW-1:0]] <= bd_wdata;
  end

endmodule

// File: tb/tb_qspi_psram_responder.sv
// Bench for qspi_psram_responder: bus reads/writes driven nibble by nibble,
// read nibbles checked against a reference byte array through a queue.
module tb_qspi_psram_responder;

  localparam int MEM_BYTES = 256;
  localparam int DUMMY     = 6;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DUMMY  = 3'd3;
  localparam logic [2:0] ST_WDATA  = 3'd5;
  localparam logic [2:0] ST_IGNORE = 3'd6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs_n = 1'b1;
  logic        sclk = 1'b0;
  logic [3:0]  io_in = 4'h0;
  logic [3:0]  io_out;
  logic [3:0]  io_oe;
  logic        bd_we = 1'b0;
  logic [11:0] bd_addr = 12'h0;
  logic [7:0]  bd_wdata = 8'h0;
  logic        bad_cmd;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int half = 1;
  int bad_pulses = 0;
  logic [3:0] exp_q[$];
  logic [7:0] model_mem [MEM_BYTES];

  qspi_psram_responder #(.MEM_BYTES(MEM_BYTES), .DUMMY_CYCLES(DUMMY)) dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .sclk(sclk), .io_in(io_in),
    .io_out(io_out), .io_oe(io_oe), .bd_we(bd_we), .bd_addr(bd_addr),
    .bd_wdata(bd_wdata), .bad_cmd(bad_cmd), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) if (bad_cmd) bad_pulses++;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic bd_write(input logic [11:0] a, input logic [7:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_wdata = d;
    model_mem[a[7:0]] = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic sclk_cycle(input logic [3:0] d);
    io_in = d;
    sclk = 1'b1;
    repeat (half) @(negedge clk);
    sclk = 1'b0;
    repeat (half) @(negedge clk);
  endtask

  task automatic cs_begin();
    @(negedge clk);
    cs_n = 1'b0;
  endtask

  task automatic cs_end();
    sclk = 1'b0;
    cs_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [7:0] c);
    for (int i = 7; i >= 0; i--) sclk_cycle({3'($urandom_range(0, 7)), c[i]});
  endtask

  task automatic send_addr(input logic [23:0] a);
    for (int i = 5; i >= 0; i--) sclk_cycle(a[i*4 +: 4]);
  endtask

  task automatic bus_read(input logic [23:0] a, input int nbytes, input int abort_at);
    logic [7:0] ix;
    logic [7:0] b;
    logic [3:0] exp;
    for (int i = 0; i < nbytes; i++) begin
      ix = a[7:0] + 8'(i);
      b = model_mem[ix];
      exp_q.push_back(b[7:4]);
      exp_q.push_back(b[3:0]);
    end
    cs_begin();
    send_cmd(8'hEB);
    send_addr(a);
    check("dummy_state", 32'(dbg_state), 32'(ST_DUMMY));
    check("dummy_oe", 32'(io_oe), 32'h0);
    repeat (DUMMY - 1) sclk_cycle(4'($urandom_range(0, 15)));
    for (int n = 0; n < 2 * nbytes; n++) begin
      if (n == abort_at) begin
        #2 rst_n = 1'b0;
        #1 check("rst_oe", 32'(io_oe), 32'h0);
        check("rst_out", 32'(io_out), 32'h0);
        exp_q.delete();
        cs_n = 1'b1;
        sclk = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        return;
      end
      sclk_cycle(4'($urandom_range(0, 15)));
      if (exp_q.size() == 0) begin
        check("rd_queue_empty", 32'(n), 32'hFFFF_FFFF);
      end else begin
        exp = exp_q.pop_front();
        check("rd_nib", 32'(io_out), 32'(exp));
      end
      check("rd_oe", 32'(io_oe), 32'hF);
    end
    cs_end();
    check("end_oe", 32'(io_oe), 32'h0);
  endtask

  // leaves cs_n low so the caller can observe the state before ending
  task automatic bus_write(input logic [23:0] a, input int nnib, input logic [31:0] nibs);
    logic [3:0] nib;
    logic [3:0] prev;
    logic [7:0] ix;
    prev = 4'h0;
    cs_begin();
    send_cmd(8'h38);
    send_addr(a);
    for (int k = 0; k < nnib; k++) begin
      nib = nibs[31 - 4*k -: 4];
      sclk_cycle(nib);
      if (k % 2 == 1) begin
        ix = a[7:0] + 8'(k / 2);
        model_mem[ix] = {prev, nib};
      end
      prev = nib;
    end
  endtask

  // scenario sequence and final report
  initial begin
    int pulses0;
    logic oe_seen;
    logic [23:0] ra;
    logic [7:0] d0, d1;

    repeat (3) @(negedge clk);
    check("reset_io_out", 32'(io_out), 32'h0);
    check("reset_io_oe", 32'(io_oe), 32'h0);
    check("reset_bad_cmd", 32'(bad_cmd), 32'h0);
    check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    bd_write(12'h010, 8'hA5);
    bd_write(12'h011, 8'h3C);
    bd_write(12'h012, 8'h00);
    bd_write(12'h013, 8'hFF);
    bd_write(12'h021, 8'h77);
    bd_write(12'h0FF, 8'hEE);
    bd_write(12'h000, 8'hDD);

    bus_read(24'h000010, 4, -1);

    bus_write(24'h0000FF, 4, 32'h1122_0000);
    cs_end();
    bus_read(24'h0000FF, 2, -1);

    pulses0 = bad_pulses;
    cs_begin();
    send_cmd(8'h9F);
    oe_seen = 1'b0;
    repeat (20) begin
      sclk_cycle(4'($urandom_range(0, 15)));
      if (io_oe != 4'h0) oe_seen = 1'b1;
    end
    check("bad_cmd_pulses", 32'(bad_pulses - pulses0), 32'd1);
    check("ignore_oe", 32'(oe_seen), 32'h0);
    check("ignore_state", 32'(dbg_state), 32'(ST_IGNORE));
    cs_end();
    bus_read(24'h000010, 2, -1);

    bus_write(24'h000020, 3, 32'h1230_0000);
    check("partial_state", 32'(dbg_state), 32'(ST_WDATA));
    sclk = 1'b0;
    cs_n = 1'b1;
    @(negedge clk);
    check("partial_idle", 32'(dbg_state), 32'(ST_IDLE));
    repeat (2) @(negedge clk);
    bus_read(24'h000020, 2, -1);

    bus_read(24'h000010, 2, 3);
    check("post_reset_state", 32'(dbg_state), 32'(ST_IDLE));
    bus_read(24'h000010, 2, -1);

    bus_read(24'h123410, 2, -1);
    half = 2;
    bus_read(24'h123410, 2, -1);
    half = 1;

    repeat (3) begin
      ra = 24'($urandom_range(32'h80, 32'hF0));
      d0 = 8'($urandom_range(0, 255));
      d1 = 8'($urandom_range(0, 255));
      bus_write(ra, 4, {d0, d1, 16'h0});
      cs_end();
      bus_read(ra, 2, -1);
    end

    check("total_bad_pulses", 32'(bad_pulses), 32'd1);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
